// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

    localparam int TIME_W  = 8;
    localparam int SEC_MAX = 59;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE,
        FULL
    } sw_state_t;

    // Width of a counter that holds 0..div-1; never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered rising-edge detector that emits one pulse per press.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button events, prescaled tick, clear pulse and display
// register. Define STOPWATCH_LAP_EN to build in the LAP state and display freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int MAX_MIN = 99
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start_stop,
    input  logic              btn_lap_reset,
    input  logic [TIME_W-1:0] cnt_minutes,
    input  logic [TIME_W-1:0] cnt_seconds,
    output logic              tick_en,
    output logic              cnt_clear,
    output logic [TIME_W-1:0] disp_minutes,
    output logic [TIME_W-1:0] disp_seconds,
    output logic              running,
    output logic              lap_active,
    output logic              full
);

    localparam int            DIV        = CLK_HZ / TICK_HZ;
    localparam int            PW         = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    sw_state_t         r_state;
    sw_state_t         w_next;
    logic              w_ss;
    logic              w_lr;
    logic              w_lr_ev;
    logic              w_at_max;
    logic              w_counting;
    logic              w_clear_nxt;
    logic [PW-1:0]     r_presc;
    logic              r_clear;
    logic              r_running;
    logic              r_full;
    logic [TIME_W-1:0] r_disp_min;
    logic [TIME_W-1:0] r_disp_sec;

    btn_sync_edge u_sync_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start_stop),
        .pulse (w_ss)
    );

    btn_sync_edge u_sync_lr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap_reset),
        .pulse (w_lr)
    );

    // A start/stop event in the same cycle swallows the lap/reset event.
    assign w_lr_ev    = w_lr & ~w_ss;
    assign w_at_max   = (cnt_minutes == TIME_W'(MAX_MIN)) && (cnt_seconds == TIME_W'(SEC_MAX));
    assign w_counting = (r_state == RUN) || (r_state == LAP);
    assign tick_en    = w_counting && (r_presc == PRESC_LAST) && !w_at_max;

    always_comb begin
        w_next      = r_state;
        w_clear_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss) begin
                    w_next = RUN;
                end else if (w_lr_ev) begin
                    w_clear_nxt = 1'b1;
                end
            end
            RUN: begin
                if (w_ss) begin
                    w_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (w_lr_ev) begin
                    w_next = LAP;
`endif
                end else if (w_at_max) begin
                    w_next = FULL;
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (w_ss) begin
                    w_next = PAUSE;
                end else if (w_lr_ev) begin
                    w_next = RUN;
                end else if (w_at_max) begin
                    w_next = FULL;
                end
            end
`endif
            PAUSE: begin
                if (w_ss) begin
                    w_next = RUN;
                end else if (w_lr_ev) begin
                    w_next      = IDLE;
                    w_clear_nxt = 1'b1;
                end
            end
            FULL: begin
                if (w_lr_ev) begin
                    w_next      = IDLE;
                    w_clear_nxt = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_clear   <= 1'b0;
            r_running <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_clear   <= w_clear_nxt;
            r_running <= (w_next == RUN) || (w_next == LAP);
            r_full    <= (w_next == FULL);
        end
    end

    // PAUSE keeps the sub-second residue so a resumed run loses no time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if ((r_state == IDLE) || (r_state == FULL) || r_clear) begin
            r_presc <= '0;
        end else if (w_counting) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_lap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap <= 1'b0;
        end else begin
            r_lap <= (w_next == LAP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp_min <= '0;
            r_disp_sec <= '0;
        end else if (r_state != LAP) begin
            r_disp_min <= cnt_minutes;
            r_disp_sec <= cnt_seconds;
        end
    end

    assign lap_active = r_lap;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp_min <= '0;
            r_disp_sec <= '0;
        end else begin
            r_disp_min <= cnt_minutes;
            r_disp_sec <= cnt_seconds;
        end
    end

    assign lap_active = 1'b0;
`endif

    assign cnt_clear    = r_clear;
    assign running      = r_running;
    assign full         = r_full;
    assign disp_minutes = r_disp_min;
    assign disp_seconds = r_disp_sec;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch. It sequences the time_counter datapath through start/stop, lap-hold, clear and saturation. It turns two debounced push-button levels into a 1-cycle count-enable tick (prescaled from clk), a clear pulse, and a registered display copy of minutes/seconds that can be frozen for lap display. It sits between the button debouncers and time_counter/7-seg driver.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, count-enable rate; DIV = CLK_HZ/TICK_HZ, must be >= 2 and an exact integer
MAX_MIN, 99, minutes value at which the stopwatch saturates (with seconds = 59)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_start_stop  in  1  debounced level, asynchronous to clk
btn_lap_reset  in  1  debounced level, asynchronous to clk
cnt_minutes  in  8  current minutes from time_counter, binary
cnt_seconds  in  8  current seconds from time_counter, binary 0..59
tick_en  out  1  1-cycle pulse: time_counter advances one second
cnt_clear  out  1  1-cycle pulse: time_counter loads 00:00
disp_minutes  out  8  registered display minutes
disp_seconds  out  8  registered display seconds
running  out  1  high in RUN or LAP
lap_active  out  1  high in LAP (display frozen)
full  out  1  high in FULL

Behaviour:
- Reset (reset=0, async): state=IDLE, prescaler=0. All outputs 0. Synchronizer flops = 0.
- Button path: each button goes through a 2-flop synchronizer, then rising-edge detect.
  - A level rising before clk edge N produces an internal event at edge N+2.
  - The state change is visible after edge N+3.
  - Held buttons give one event only.
- States: IDLE, RUN, LAP, PAUSE, FULL.
  - IDLE: ss -> RUN. lr -> stay in IDLE, cnt_clear pulse.
  - RUN: ss -> PAUSE. lr -> LAP and latch cnt values into the display. at_max -> FULL.
  - LAP: ss -> PAUSE, display resumes live. lr -> RUN, display resumes live. at_max -> FULL, display resumes live.
  - PAUSE: ss -> RUN. lr -> IDLE, cnt_clear pulse.
  - FULL: lr -> IDLE, cnt_clear pulse. ss is ignored.
- Simultaneous ss and lr events in the same cycle: ss wins, lr is discarded.
- at_max = (cnt_minutes == MAX_MIN) && (cnt_seconds == 59).
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP.
  - Holds its value in PAUSE, so the sub-second residue is preserved.
  - Forced to 0 in IDLE, in FULL, and in any cycle where cnt_clear = 1.
- tick_en = 1 for exactly one cycle when the prescaler == DIV-1 in RUN/LAP and !at_max. The prescaler wraps to 0 on that cycle.
  - First tick comes DIV cycles after entering RUN from IDLE.
  - tick_en is never asserted while at_max, so no 99:59 -> 00:00 wrap.
- cnt_clear is registered: asserted the cycle after the lr event is decoded, for exactly 1 cycle.
- Display registers:
  - Every cycle outside LAP: disp <= cnt (1-cycle latency).
  - In LAP: hold the value latched on LAP entry.
  - On leaving LAP: live again from the next edge.
- Flags: running, lap_active and full are registered decodes of the next state, aligned with the state register.
- Reset asserted mid-operation: immediate return to the reset values. No cnt_clear pulse is produced; time_counter has its own reset.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined: LAP state and display freeze as above.
- Undefined:
  - No LAP state.
  - lr in RUN is ignored.
  - disp is always a 1-cycle copy of cnt.
  - lap_active is tied 0.
  - lr in IDLE, PAUSE and FULL is unchanged.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum (IDLE, RUN, LAP, PAUSE, FULL)
  - SEC_MAX = 59
  - TIME_W = 8
  - function for the prescaler width, clog2(DIV)
- One sub-module, btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, same clk/reset, instantiated twice.

Test Plan:
- Common setup: CLK_HZ=10, TICK_HZ=1 (DIV=10), behavioural time_counter model.
- Scenario 1, start and time: reset released, ss pulse at cycle 5 -> running=1 after edge 8; tick_en at cycles 18, 28, 38; counter reads 00:03.
- Scenario 2, pause/resume: pause at prescaler=4 with ss, resume with ss -> first tick 5 cycles after resume; no tick while paused; disp stable.
- Scenario 3, lap: lr in RUN at 00:07 -> lap_active=1, disp holds 00:07 while the counter reaches 00:12; lr again -> disp = 00:12 one cycle later.
- Scenario 4, saturation: preload counter to 99:58, RUN -> one tick to 99:59, then full=1 and no further tick_en for 100 cycles; lr -> IDLE, cnt_clear 1 cycle, counter 00:00.
- Scenario 5, simultaneous events: ss and lr rise in the same cycle in RUN -> PAUSE, no lap latch; clear from PAUSE with lr -> IDLE plus one cnt_clear pulse; holding lr 50 cycles gives a single pulse.
- Scenario 6, reset mid-run: reset=0 asynchronously mid-cycle in LAP -> all outputs 0 immediately, state IDLE; build without STOPWATCH_LAP_EN -> lr in RUN is a no-op.
